// File: rtl/instr_mem_param.sv
// Parameterised instruction memory: NOP-fill sweep after reset, then single-port
// fetch with a one-entry registered response and a program-load write port.
module instr_mem_param #(
   parameter int          DEPTH    = 64,
   parameter int          ADDR_W   = 32,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       instr_out,
   output logic              fault,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   output logic              busy
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state_reg;
   logic [IDX_W-1:0]  sweep_reg;
   logic [31:0]       mem [DEPTH];

   logic [ADDR_W-1:0] req_word;
   logic [ADDR_W-1:0] load_word;
   logic              req_ok;
   logic              load_ok;
   logic              fetch_accept;

   assign req_word  = req_addr >> 2;
   assign load_word = load_addr >> 2;
   assign req_ok    = (req_addr[1:0] == 2'b00) && (req_word < DEPTH_A);
   assign load_ok   = load_en && (load_addr[1:0] == 2'b00) && (load_word < DEPTH_A);

   // A load cycle never accepts a fetch, so read and write never collide.
   assign req_ready    = (state_reg == RUN) && !load_en && (!resp_valid || resp_ready);
   assign fetch_accept = req_valid && req_ready;
   assign busy         = (state_reg == INIT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= INIT;
         sweep_reg <= '0;
      end else begin
         case (state_reg)
            INIT: begin
               if (sweep_reg == LAST_IDX) begin
                  state_reg <= RUN;
                  sweep_reg <= '0;
               end else begin
                  sweep_reg <= sweep_reg + 1'b1;
               end
            end
            default: state_reg <= RUN;
         endcase
      end
   end

   // Storage carries no reset so it maps onto block RAM; the INIT sweep clears it.
   always_ff @(posedge clk) begin
      if (state_reg == INIT) begin
         mem[sweep_reg] <= NOP_WORD;
      end else if (load_ok) begin
         mem[load_word[IDX_W-1:0]] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resp_valid <= 1'b0;
         fault      <= 1'b0;
         instr_out  <= NOP_WORD;
      end else if (fetch_accept) begin
         resp_valid <= 1'b1;
         fault      <= !req_ok;
         instr_out  <= req_ok ? mem[req_word[IDX_W-1:0]] : NOP_WORD;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/instr_mem_param.md
INSTR_MEM_PARAM -- requirements
Module: instr_mem_param

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit instruction words stored.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the byte address ports.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, fill and fault instruction (addi x0,x0,0).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_addr  input  ADDR_W  fetch byte address.
REQ-008 req_ready  output  1  fetch request accepted this cycle when high with req_valid.
REQ-009 resp_valid  output  1  instr_out/fault hold a fetch result.
REQ-010 resp_ready  input  1  consumer takes the result this cycle.
REQ-011 instr_out  output  32  fetched instruction.
REQ-012 fault  output  1  result came from a misaligned or out-of-range address.
REQ-013 load_en  input  1  program-load write strobe.
REQ-014 load_addr  input  ADDR_W  program-load byte address.
REQ-015 load_data  input  32  program-load word.
REQ-016 busy  output  1  block is in INIT sweep.

Function
REQ-017 SHALL implement the states INIT and RUN.
REQ-018 SHALL, in INIT, write NOP_WORD to word index 0,1,...,DEPTH-1, one word per cycle, then enter RUN on the cycle after index DEPTH-1 is written (INIT lasts exactly DEPTH cycles).
REQ-019 SHALL hold busy high exactly while in INIT; req_ready SHALL be low and load_en SHALL be ignored in INIT.
REQ-020 SHALL address storage by word index = addr >> 2; byte offset addr[1:0] is not used for indexing.
REQ-021 SHALL drive req_ready high in RUN when load_en is low and the output register is empty or resp_ready is high.
REQ-022 SHALL, on an accepted fetch (req_valid & req_ready), register the result on that clock edge: resp_valid high next cycle (1-cycle latency).
REQ-023 SHALL return NOP_WORD with fault=1 when req_addr[1:0]!=0 or word index >= DEPTH; otherwise stored word with fault=0.
REQ-024 SHALL hold instr_out, fault and resp_valid stable while resp_valid=1 and resp_ready=0.
REQ-025 SHALL clear resp_valid after resp_valid & resp_ready unless a new fetch is accepted in the same cycle (back-to-back: one result per cycle, no bubble).
REQ-026 SHALL, in RUN with load_en=1, write load_data to word index of load_addr when aligned and in range; misaligned or out-of-range loads are silently dropped.
REQ-027 SHALL give load priority: load_en=1 forces req_ready=0 that cycle, so a fetch is never accepted in a load cycle.
REQ-028 SHALL return the newly loaded word to any fetch of that address accepted in any cycle after the load cycle.
REQ-029 SHALL use no combinational path from req_addr to instr_out.

Reset
REQ-030 SHALL, on reset assertion at any time including mid-INIT or with a pending response, immediately force state=INIT, sweep index=0, resp_valid=0, fault=0, instr_out=NOP_WORD, busy=1, req_ready=0.
REQ-031 SHALL restart the full DEPTH-cycle sweep after reset deassertion, overwriting all previously loaded contents.

Verification
REQ-032 DEPTH=16: release reset -> busy high exactly 16 cycles, then fetch 0x3C -> instr_out=32'h00000013, fault=0.
REQ-033 Load 0x8 <= 32'h00500093, next cycle fetch 0x8 -> next cycle resp_valid=1, instr_out=32'h00500093, fault=0.
REQ-034 Fetch 0x6 (misaligned) and 0x40 (DEPTH=16, out of range) -> instr_out=32'h00000013, fault=1 each; load to 0x40 leaves all words unchanged.
REQ-035 Fetch with resp_ready=0 for 3 cycles -> req_ready=0, outputs stable; then resp_ready=1 with req_valid=1 each cycle to 0x0,0x4,0x8 -> three results on consecutive cycles.
REQ-036 load_en=1 and req_valid=1 same cycle -> req_ready=0, write done; fetch accepted the following cycle returns the new data.
REQ-037 Assert reset mid-INIT (cycle 5) and with resp_valid=1 -> resp_valid=0 immediately; after release busy lasts full 16 cycles and previously loaded words read as NOP_WORD.
